// File: rtl/wisc_mem_pkg.sv
// Shared types and constants for the WISC cache/memory arbitration path.
package wisc_mem_pkg;

    localparam int unsigned ADDR_W              = 16;
    localparam int unsigned DATA_W              = 16;
    localparam int unsigned WORDS_PER_BLOCK_DEF = 8;
    localparam int unsigned MEM_LATENCY_DEF     = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    // One-hot requester vector used for grant and fill_done.
    function automatic logic [1:0] owner_onehot(input owner_e o);
        return (o == OWN_D) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/cache_fill_seq.sv
// Block-fill sequencer: read issue counter, return counter, base address
// generation and last-word detection for one cache-block fill.
module cache_fill_seq
    import wisc_mem_pkg::*;
#(
    parameter int unsigned WORDS_PER_BLOCK = WORDS_PER_BLOCK_DEF
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start_i,
    input  logic [ADDR_W-1:0]                  addr_i,
    input  logic                               active_i,
    input  logic                               valid_i,
    output logic                               issue_o,
    output logic [ADDR_W-1:0]                  rd_addr_o,
    output logic [$clog2(WORDS_PER_BLOCK)-1:0] recv_idx_o,
    output logic                               last_o
);

    localparam int unsigned IDX_W = $clog2(WORDS_PER_BLOCK);
    localparam int unsigned CNT_W = IDX_W + 1;
    localparam logic [ADDR_W-1:0] BLK_MASK = ADDR_W'(2 * WORDS_PER_BLOCK - 1);

    logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
    logic [IDX_W-1:0]  recv_cnt_q,  recv_cnt_d;
    logic [ADDR_W-1:0] base_q,      base_d;

    // Issue/return status and next counter/base values.
    always_comb begin
        issue_o    = active_i && (issue_cnt_q < CNT_W'(WORDS_PER_BLOCK));
        rd_addr_o  = base_q + ADDR_W'({issue_cnt_q, 1'b0});
        recv_idx_o = recv_cnt_q;
        last_o     = active_i && valid_i && (recv_cnt_q == '1);

        issue_cnt_d = issue_cnt_q;
        recv_cnt_d  = recv_cnt_q;
        base_d      = base_q;
        if (start_i) begin
            base_d      = addr_i & ~BLK_MASK;
            issue_cnt_d = '0;
            recv_cnt_d  = '0;
        end else if (active_i) begin
            if (issue_o) issue_cnt_d = issue_cnt_q + 1'b1;
            if (valid_i) recv_cnt_d  = recv_cnt_q + 1'b1;
        end
    end

    // Counter and base registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            issue_cnt_q <= '0;
            recv_cnt_q  <= '0;
            base_q      <= '0;
        end else begin
            issue_cnt_q <= issue_cnt_d;
            recv_cnt_q  <= recv_cnt_d;
            base_q      <= base_d;
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates the single memory port between I-cache and D-cache block fills
// (D wins ties) and passes D-side store-through writes while idle.
module cache_mem_arbiter
    import wisc_mem_pkg::*;
#(
    parameter int unsigned WORDS_PER_BLOCK = WORDS_PER_BLOCK_DEF,
    parameter int unsigned MEM_LATENCY     = MEM_LATENCY_DEF
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               i_miss_req,
    input  logic [ADDR_W-1:0]                  i_miss_addr,
    input  logic                               d_miss_req,
    input  logic [ADDR_W-1:0]                  d_miss_addr,
    input  logic                               wr_req,
    input  logic [ADDR_W-1:0]                  wr_addr,
    input  logic [DATA_W-1:0]                  wr_data,
    output logic                               wr_ack,
    output logic [1:0]                         grant,
    output logic                               fill_we,
    output logic [$clog2(WORDS_PER_BLOCK)-1:0] fill_word_idx,
    output logic [DATA_W-1:0]                  fill_data,
    output logic                               fill_tag_we,
    output logic [1:0]                         fill_done,
    output logic                               busy,
    output logic                               mem_en,
    output logic                               mem_wr,
    output logic [ADDR_W-1:0]                  mem_addr,
    output logic [DATA_W-1:0]                  mem_data_in,
    input  logic [DATA_W-1:0]                  mem_data_out,
    input  logic                               mem_data_valid
);

    // Fill timing follows the memory's own latency; it only has to be legal.
    if (MEM_LATENCY < 1 || WORDS_PER_BLOCK < 2 ||
        (WORDS_PER_BLOCK & (WORDS_PER_BLOCK - 1)) != 0) begin : g_param_check
        $error("cache_mem_arbiter: illegal WORDS_PER_BLOCK or MEM_LATENCY");
    end

    arb_state_e state_q, state_d;
    owner_e     owner_q, owner_d;

    logic                               seq_start;
    logic                               seq_issue;
    logic                               seq_last;
    logic [ADDR_W-1:0]                  seq_rd_addr;
    logic [$clog2(WORDS_PER_BLOCK)-1:0] seq_idx;
    logic [ADDR_W-1:0]                  req_addr;
    logic                               in_fill;

    assign in_fill  = (state_q == ST_FILL);
    assign req_addr = d_miss_req ? d_miss_addr : i_miss_addr;

    cache_fill_seq #(
        .WORDS_PER_BLOCK(WORDS_PER_BLOCK)
    ) u_fill_seq (
        .clk        (clk),
        .rst        (rst),
        .start_i    (seq_start),
        .addr_i     (req_addr),
        .active_i   (in_fill),
        .valid_i    (mem_data_valid),
        .issue_o    (seq_issue),
        .rd_addr_o  (seq_rd_addr),
        .recv_idx_o (seq_idx),
        .last_o     (seq_last)
    );

    // Next-state, priority select, write pass-through and fill outputs.
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        seq_start     = 1'b0;
        wr_ack        = 1'b0;
        grant         = 2'b00;
        fill_we       = 1'b0;
        fill_word_idx = '0;
        fill_data     = '0;
        fill_tag_we   = 1'b0;
        fill_done     = 2'b00;
        busy          = (state_q != ST_IDLE);
        mem_en        = 1'b0;
        mem_wr        = 1'b0;
        mem_addr      = '0;
        mem_data_in   = '0;

        if (state_q != ST_IDLE) grant = owner_onehot(owner_q);

        case (state_q)
            ST_IDLE: begin
                if (wr_req) begin
                    mem_en      = 1'b1;
                    mem_wr      = 1'b1;
                    mem_addr    = wr_addr;
                    mem_data_in = wr_data;
                    wr_ack      = 1'b1;
                end
                if (i_miss_req || d_miss_req) begin
                    seq_start = 1'b1;
                    owner_d   = d_miss_req ? OWN_D : OWN_I;
                    state_d   = ST_FILL;
                end
            end
            ST_FILL: begin
                if (seq_issue) begin
                    mem_en   = 1'b1;
                    mem_addr = seq_rd_addr;
                end
                if (mem_data_valid) begin
                    fill_we       = 1'b1;
                    fill_word_idx = seq_idx;
                    fill_data     = mem_data_out;
                end
                if (seq_last) state_d = ST_DONE;
            end
            ST_DONE: begin
                fill_done   = owner_onehot(owner_q);
                fill_tag_we = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and owner registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            owner_q <= OWN_I;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Shares the single-ported, fixed-latency main memory between the instruction-cache and data-cache miss handlers of the WISC pipelined CPU, and sequences each cache-block fill. Data-side store-through writes are also issued through this block. It sits between the two caches and the unified memory model. It replaces the direct CPU-to-memory connection used by the single-cycle data memory.

## Interface
- WORDS_PER_BLOCK, 8: 16-bit words per cache block; power of two.
- MEM_LATENCY, 4: cycles from read issue to `mem_data_valid`; ≥1.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset; synchronous and active-high.
- i_miss_req  in  1  I-cache miss pending; held until `fill_done[0]`.
- i_miss_addr  in  16  I-cache miss byte address.
- d_miss_req  in  1  D-cache miss pending; held until `fill_done[1]`.
- d_miss_addr  in  16  D-cache miss byte address.
- wr_req  in  1  D-cache store-through request; held until `wr_ack`.
- wr_addr / wr_data  in  16 / 16  store address and data.
- wr_ack  out  1  write issued this cycle.
- grant  out  2  one-hot owner of the active fill (bit0 = I, bit1 = D).
- fill_we  out  1  write one returned word into the owner's data array.
- fill_word_idx  out  log2(WORDS_PER_BLOCK)  word index for `fill_we`.
- fill_data  out  16  returned word.
- fill_tag_we  out  1  write tag/valid for the owner's block (same cycle as `fill_done`).
- fill_done  out  2  one-cycle completion pulse per requester.
- busy  out  1  state ≠ IDLE.
- mem_en, mem_wr  out  1, 1  memory enable and write select.
- mem_addr, mem_data_in  out  16, 16  memory address and write data.
- mem_data_out  in  16  memory read data.
- mem_data_valid  in  1  read data valid.

## Operation
- States: IDLE, FILL, DONE.
- IDLE:
  - If `wr_req` is high: drive `mem_en=1`, `mem_wr=1`, `mem_addr=wr_addr`, `mem_data_in=wr_data`, and `wr_ack=1`, all combinationally in the same cycle.
  - If any miss request is high: latch the owner and `base = addr & ~(2*WORDS_PER_BLOCK-1)`, clear both counters, then go to FILL. D-cache wins when both requests are high.
  - A write and a miss may be accepted in the same IDLE cycle, because the write uses the port before the fill starts.
- FILL:
  - While `issue_cnt < WORDS_PER_BLOCK`: drive `mem_en=1`, `mem_wr=0`, `mem_addr = base + 2*issue_cnt`, then increment `issue_cnt`. One read is issued per cycle.
  - On each `mem_data_valid`: drive `fill_we=1`, `fill_word_idx=recv_cnt`, `fill_data=mem_data_out`, then increment `recv_cnt`.
  - When the valid word with `recv_cnt = WORDS_PER_BLOCK-1` arrives, go to DONE.
  - `wr_req` is not acknowledged during FILL or DONE.
- DONE:
  - `fill_done[owner]=1` and `fill_tag_we=1` for one cycle, then go to IDLE.
  - `grant` is held through DONE and cleared in IDLE.
- Address arithmetic is 16-bit modulo. `base + 2*i` never carries out of the block because `base` is block-aligned.
- `mem_data_valid` outside FILL is ignored.
- Protocol rules on the requesters:
  - A requester must deassert its miss request in the cycle after its `fill_done`.
  - A miss address must be stable while its request is high.
- I-cache starvation is bounded: the D-cache cannot re-miss while the pipeline is stalled on its own fill.

## Timing
- Reset values: state IDLE, counters 0, `grant=0`, and every other output 0.
- Reset mid-fill aborts the fill with no `fill_done`. The memory model shares `rst` and drops in-flight reads.
- Fill latency, with the miss request seen in IDLE at cycle 0:
  - Reads issued in cycles 1..W.
  - `fill_we` in cycles 1+L..W+L.
  - `fill_done` in cycle W+L+1.
  - IDLE again in cycle W+L+2.
  - W = WORDS_PER_BLOCK, L = MEM_LATENCY.
  - Defaults: fill_done at cycle 13, back-to-back fill granted at cycle 14.
- Write latency: 0 cycles (`wr_ack` in the request cycle) when in IDLE.

## Structure
- Package `wisc_mem_pkg`:
  - state enum.
  - `ADDR_W=16`, `DATA_W=16`.
  - owner encoding (`OWN_I=0`, `OWN_D=1`).
  - default WORDS_PER_BLOCK and MEM_LATENCY.
- Sub-module `cache_fill_seq` owns `issue_cnt`, `recv_cnt`, base-address generation and last-word detect.
- `cache_mem_arbiter` owns the FSM, priority selection and write pass-through.

## Test plan
All cases use default parameters unless stated.
- I miss 0x1234 at cycle 0:
  - `mem_addr` 0x1230..0x123E in cycles 1–8.
  - `fill_we` with idx 0..7 in cycles 5–12.
  - `fill_done=2'b01` and `fill_tag_we` in cycle 13.
- I miss 0x0040 and D miss 0x8008 both at cycle 0:
  - D granted first (base 0x8000), `fill_done[1]` in cycle 13.
  - I granted at cycle 14 (base 0x0040), `fill_done[0]` in cycle 27.
- `wr_req` (0x2002, 0xBEEF) at cycle 3 of an I fill:
  - No `wr_ack` until cycle 14.
  - Exactly one memory write of 0xBEEF to 0x2002.
- `wr_req` and D miss together in IDLE:
  - Write issued and `wr_ack` in cycle 0.
  - Fill reads start in cycle 1.
- `rst` asserted in cycle 6 of a fill:
  - All outputs 0 in cycle 7; no `fill_done`.
  - A new I miss afterwards completes normally with `fill_done` 13 cycles after it is seen in IDLE.
- MEM_LATENCY=1, WORDS_PER_BLOCK=4, D miss 0xFFFE:
  - Reads to 0xFFF8..0xFFFE.
  - `fill_done[1]` in cycle 6.
